tube_display_ctrl: RTL and testbench

Sequencer for the 4-digit multiplexed 7-segment driver.
- Accepts a binary value over a valid/ready handshake.
- Converts the value to four BCD digits with an iterative shift-add-3 (double-dabble) engine, saturating at 9999.
- Presents all four digits atomically to the driver.
- Generates the driver's periodic scan-enable pulse from the system clock.

---
 rtl/tube_display_ctrl.sv | 129 ++++++++++++
 tb/tb_tube_display_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tube_display_ctrl.sv
// 4-digit 7-segment sequencer: binary intake, double-dabble BCD conversion
// with 9999 saturation, atomic digit update and periodic scan-enable.
module tube_display_ctrl #(
    parameter int CLK_DIV = 50000,
    parameter int VAL_W   = 14
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bin_valid,
    input  logic [VAL_W-1:0] bin_data,
    output logic             bin_ready,
    output logic             scan_en,
    output logic [3:0]       single_digit,
    output logic [3:0]       ten_digit,
    output logic [3:0]       hundred_digit,
    output logic [3:0]       kilo_digit,
    output logic             ovf
);

    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    localparam logic [VAL_W-1:0] MAX_VAL  = VAL_W'(9999);
    localparam logic [3:0]       LAST_BIT = 4'(VAL_W - 1);
    localparam logic [CNT_W-1:0] SCAN_TOP = CNT_W'(CLK_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [VAL_W-1:0] sr_q, sr_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      acc_adj;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [15:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic             over;

    assign bin_ready     = (state_q == S_IDLE);
    assign scan_en       = (scan_cnt_q == SCAN_TOP);
    assign single_digit  = disp_q[3:0];
    assign ten_digit     = disp_q[7:4];
    assign hundred_digit = disp_q[11:8];
    assign kilo_digit    = disp_q[15:12];
    assign ovf           = ovf_q;
    assign over          = (bin_data > MAX_VAL);

    // Free-running scan divider, unaffected by the conversion FSM.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        if (scan_cnt_q == SCAN_TOP) begin
            scan_cnt_d = '0;
        end
    end

    // Add-3 correction on every BCD nibble that would overflow when doubled.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Intake / shift / load sequencing; display only changes in LOAD.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bin_valid) begin
                    sr_d       = over ? MAX_VAL : bin_data;
                    ovf_pend_d = over;
                    acc_d      = '0;
                    bit_cnt_d  = LAST_BIT;
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                {acc_d, sr_d} = {acc_adj, sr_q} << 1;
                if (bit_cnt_q == 4'd0) begin
                    state_d = S_LOAD;
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            S_LOAD: begin
                disp_d  = acc_q;
                ovf_d   = ovf_pend_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any conversion and blanks the display.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            scan_cnt_q <= '0;
            sr_q       <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_tube_display_ctrl.sv
// Directed and randomized checks for tube_display_ctrl:
// handshake timing, BCD results, saturation, reset abort, scan period.
module tb_tube_display_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bin_valid = 1'b0;
    logic [13:0] bin_data = '0;
    logic        bin_ready;
    logic        scan_en;
    logic [3:0]  single_digit;
    logic [3:0]  ten_digit;
    logic [3:0]  hundred_digit;
    logic [3:0]  kilo_digit;
    logic        ovf;

    logic [16:0] disp;
    int          n_cmp = 0;
    int          n_err = 0;
    int          edges = 0;

    tube_display_ctrl #(
        .CLK_DIV(DIV),
        .VAL_W  (14)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bin_valid    (bin_valid),
        .bin_data     (bin_data),
        .bin_ready    (bin_ready),
        .scan_en      (scan_en),
        .single_digit (single_digit),
        .ten_digit    (ten_digit),
        .hundred_digit(hundred_digit),
        .kilo_digit   (kilo_digit),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    assign disp = {kilo_digit, hundred_digit, ten_digit, single_digit, ovf};

    // Edges since the last reset release; drives the expected scan phase.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic [16:0] model(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        model = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10),
                 4'(s % 10), (v > 9999) ? 1'b1 : 1'b0};
    endfunction

    // Presents v until accepted; returns at the falling edge of cycle T+1.
    task automatic xfer(input logic [13:0] v);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        bin_valid = 1'b1;
        bin_data  = v;
        while (!done && n < 40) begin
            done = bin_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bin_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL xfer_timeout: value %0d not accepted in %0d cycles", v, n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({disp, bin_ready, scan_en} !== {17'h0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h",
                     {disp, bin_ready, scan_en}, {17'h0, 1'b1, 1'b0});
        end
        rstn = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            n_cmp++;
            if (scan_en !== ((n % DIV) == DIV - 1)) begin
                n_err++;
                $display("FAIL scan_after_reset n=%0d: got %b want %b",
                         n, scan_en, ((n % DIV) == DIV - 1));
            end
        end
    endtask

    task automatic test_1234();
        xfer(14'd1234);
        for (int k = 1; k <= 15; k++) begin
            n_cmp++;
            if ({bin_ready, disp} !== {1'b0, 17'h0}) begin
                n_err++;
                $display("FAIL busy_1234 T+%0d: got %h want %h",
                         k, {bin_ready, disp}, {1'b0, 17'h0});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({bin_ready, disp} !== {1'b1, 16'h1234, 1'b0}) begin
            n_err++;
            $display("FAIL result_1234: got %h want %h",
                     {bin_ready, disp}, {1'b1, 16'h1234, 1'b0});
        end
    endtask

    task automatic test_saturation();
        logic [13:0] vals [4];
        logic [16:0] exp  [4];
        vals = '{14'd10000, 14'd16383, 14'd0, 14'd9999};
        exp  = '{{16'h9999, 1'b1}, {16'h9999, 1'b1},
                 {16'h0000, 1'b0}, {16'h9999, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            xfer(vals[i]);
            repeat (15) @(negedge clk);
            n_cmp++;
            if (disp !== exp[i]) begin
                n_err++;
                $display("FAIL sat_%0d: got %h want %h", vals[i], disp, exp[i]);
            end
        end
    endtask

    task automatic test_busy_hold();
        xfer(14'd42);
        bin_valid = 1'b1;
        bin_data  = 14'd777;
        for (int k = 1; k <= 15; k++) begin
            n_cmp++;
            if (bin_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_ready T+%0d: got %b want 0", k, bin_ready);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({bin_ready, disp} !== {1'b1, 16'h0042, 1'b0}) begin
            n_err++;
            $display("FAIL hold_42: got %h want %h",
                     {bin_ready, disp}, {1'b1, 16'h0042, 1'b0});
        end
        @(negedge clk);
        bin_valid = 1'b0;
        for (int k = 17; k <= 31; k++) begin
            n_cmp++;
            if ({bin_ready, disp} !== {1'b0, 16'h0042, 1'b0}) begin
                n_err++;
                $display("FAIL hold_busy2 T+%0d: got %h want %h",
                         k, {bin_ready, disp}, {1'b0, 16'h0042, 1'b0});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (disp !== {16'h0777, 1'b0}) begin
            n_err++;
            $display("FAIL hold_777: got %h want %h", disp, {16'h0777, 1'b0});
        end
    endtask

    task automatic test_reset_abort();
        xfer(14'd5678);
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bin_ready, disp} !== {1'b1, 17'h0}) begin
            n_err++;
            $display("FAIL abort_now: got %h want %h",
                     {bin_ready, disp}, {1'b1, 17'h0});
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bin_ready, disp} !== {1'b1, 17'h0}) begin
                n_err++;
                $display("FAIL abort_after k=%0d: got %h want %h",
                         k, {bin_ready, disp}, {1'b1, 17'h0});
            end
        end
    endtask

    task automatic test_back_to_back();
        int          v;
        logic [16:0] exp;
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v = int'($urandom_range(0, 16383));
            xfer(14'(v));
            for (int k = 1; k <= 15; k++) begin
                @(negedge clk);
                n_cmp++;
                if (scan_en !== ((edges % DIV) == DIV - 1)) begin
                    n_err++;
                    $display("FAIL scan_period edge=%0d: got %b", edges, scan_en);
                end
            end
            exp = model(v);
            n_cmp++;
            if ({bin_ready, disp} !== {1'b1, exp}) begin
                n_err++;
                $display("FAIL rand_%0d value=%0d: got %h want %h",
                         t, v, {bin_ready, disp}, {1'b1, exp});
            end
        end
    endtask

    initial begin
        test_reset();
        test_1234();
        test_saturation();
        test_busy_hold();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
